// File: rtl/ex_muldiv.sv
// HI/LO multiply/divide unit for the EX stage: single-cycle MULT/MULTU/MTHI/MTLO,
// 32-step restoring DIV/DIVU with sign fix-up, stalling the pipe via busy.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state | meaning
  // IDLE  | accepts start; single-cycle ops complete here
  // DIV   | one restoring-division step per cycle, 32 cycles
  // FIX   | sign correction, writes HI/LO, returns to IDLE
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             sign_a, sign_b, is_signed;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0]     shifted, diff;
  logic               take;

  // Lower 2*WIDTH bits of the extended products are exact for both signednesses.
  assign prod_s = {{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opB[WIDTH-1]}}, opB};
  assign prod_u = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};

  assign abs_a = opA[WIDTH-1] ? -opA : opA;
  assign abs_b = opB[WIDTH-1] ? -opB : opB;

  // Remainder stays below the divisor, so a borrow out of the 33-bit subtract
  // means "remainder < divisor" even when the divisor has its top bit set.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign take    = ~diff[WIDTH];

  assign q_fix = (is_signed && (sign_a ^ sign_b)) ? -quo : quo;
  assign r_fix = (is_signed && sign_a) ? -rem : rem;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {hi, lo} <= prod_s;
                done     <= 1'b1;
              end
              OP_MULTU: begin
                {hi, lo} <= prod_u;
                done     <= 1'b1;
              end
              OP_MTHI: begin
                hi   <= opA;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= opA;
                done <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (opB == '0) begin
                  done <= 1'b1;
                end else begin
                  is_signed <= (op == OP_DIV);
                  sign_a    <= opA[WIDTH-1];
                  sign_b    <= opB[WIDTH-1];
                  quo       <= (op == OP_DIV) ? abs_a : opA;
                  dvs       <= (op == OP_DIV) ? abs_b : opB;
                  rem       <= '0;
                  cnt       <= '0;
                  state     <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          rem <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], take};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_FIX;
        end
        S_FIX: begin
          lo    <= q_fix;
          hi    <= r_fix;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected {hi,lo} per completing
// op, a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  localparam logic [2:0] NOP = 3'b000, MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                         DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110, OP7 = 3'b111;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got hi=0x%h lo=0x%h, expected no done", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("done_hilo", {hi, lo}, e);
        end
      end
    end
  end

  // Drives one start strobe; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; op = NOP; opA = '0; opB = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected idle", n);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = NOP; opA = '0; opB = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy_done", {62'h0, busy, done}, 64'h0);
    rst = 1'b0;

    exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
    issue(MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_busy", {63'h0, busy}, 64'h0);

    exp_q.push_back(64'hFFFFFFFE_00000001);
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);

    exp_q.push_back({32'd2, 32'd14});
    issue(DIVU, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_busy_cycles", 64'(n), 64'd33);

    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);

    exp_q.push_back(64'h00000000_80000000);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);

    exp_q.push_back(64'h7FFFFFFE_00000001);
    issue(DIVU, 32'hFFFFFFFF, 32'h80000001);
    wait_idle(n);

    exp_q.push_back(64'h7FFFFFFE_00000001);
    issue(DIV, 32'd5, 32'd0);
    chk("div0_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    chk("div0_busy_later", {63'h0, busy}, 64'h0);

    exp_q.push_back(64'h12345678_00000001);
    issue(MTHI, 32'h12345678, 32'hFFFF0000);
    exp_q.push_back(64'h12345678_CAFEF00D);
    issue(MTLO, 32'hCAFEF00D, 32'h0);

    issue(NOP, 32'h11111111, 32'h22222222);
    issue(OP7, 32'h33333333, 32'h44444444);
    repeat (2) @(negedge clk);
    chk("nop_hilo", {hi, lo}, 64'h12345678_CAFEF00D);

    // flush while idle blocks a concurrent start
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = MTLO; opA = 32'hBBBBBBBB;
    @(negedge clk);
    flush = 1'b0; start = 1'b0; op = NOP;
    @(negedge clk);
    chk("flush_start_hilo", {hi, lo}, 64'h12345678_CAFEF00D);

    // DIVU flushed at cycle 10; a start at cycle 5 is ignored
    issue(DIVU, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    start = 1'b1; op = MTHI; opA = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; op = NOP; opA = '0;
    repeat (5) @(negedge clk);
    chk("flush_busy_c10", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_c11", {63'h0, busy}, 64'h0);
    repeat (40) @(negedge clk);
    chk("flush_hilo", {hi, lo}, 64'h12345678_CAFEF00D);
    chk("flush_busy_after", {63'h0, busy}, 64'h0);

    // reset aborts a divide mid-flight
    exp_q.push_back(64'h12345678_CAFEF00D);
    issue(MTHI, 32'h12345678, 32'h0);
    issue(DIVU, 32'd9, 32'd2);
    repeat (10) @(negedge clk);
    chk("pre_rst_hi", {32'h0, hi}, {32'h0, 32'h12345678});
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1; start = 1'b1; op = MTLO; opA = 32'h5A5A5A5A; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; op = NOP; opA = '0; flush = 1'b0;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_busy_done", {62'h0, busy, done}, 64'h0);
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {63'h0, busy}, 64'h0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; only 32 is required to be supported.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  issue strobe from EX; sampled only in IDLE.
REQ-005 op  input  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 treated as NOP.
REQ-006 opA  input  WIDTH  left operand (register-file left read value, after forwarding); dividend / multiplicand / MTHI/MTLO source.
REQ-007 opB  input  WIDTH  right operand (register-file right read value, after forwarding); divisor / multiplier.
REQ-008 flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 busy  output  1  stall request to ID/EX; high while a divide is in flight.
REQ-010 done  output  1  one-cycle pulse marking the edge HI/LO were updated.
REQ-011 hi  output  WIDTH  HI register, registered.
REQ-012 lo  output  WIDTH  LO register, registered.

Function
REQ-013 States SHALL be IDLE, DIV and FIX; busy SHALL be 1 exactly when state is DIV or FIX.
REQ-014 In IDLE with start=1 and op MULT/MULTU, {hi,lo} SHALL take the 64-bit signed/unsigned product at the next edge and done SHALL pulse that cycle; busy stays 0.
REQ-015 In IDLE with start=1 and op MTHI (MTLO), hi (lo) SHALL take opA at the next edge; the other register SHALL be unchanged; done SHALL pulse.
REQ-016 In IDLE with start=1, op DIV/DIVU and opB!=0, the block SHALL latch |opA| and |opB| (DIV) or raw values (DIVU) plus both sign bits, clear a 6-bit counter and enter DIV.
REQ-017 In IDLE with start=1, op DIV/DIVU and opB==0, hi/lo SHALL be unchanged, done SHALL pulse next cycle, and state SHALL remain IDLE.
REQ-018 DIV SHALL perform one restoring-division step per cycle (shift remainder:quotient left by 1 and subtract the divisor if the remainder >= divisor), for exactly 32 cycles, then enter FIX.
REQ-019 For DIV, FIX SHALL negate the quotient if the sign bits differ and negate the remainder if the dividend was negative; for DIVU, FIX applies no correction.
REQ-020 At the FIX edge, lo SHALL take the quotient and hi SHALL take the remainder; done SHALL pulse; state SHALL return to IDLE.
REQ-021 Divide latency: start edge at cycle 0; busy=1 in cycles 1..33; hi/lo and done are valid in cycle 34.
REQ-022 0x80000000 DIV 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0 (32-bit wrap, no trap).
REQ-023 start in DIV/FIX SHALL be ignored; the op is not queued.
REQ-024 flush=1 SHALL force IDLE at the next edge, take priority over start, leave hi/lo unchanged and suppress done.
REQ-025 NOP, op 111, or start=0 SHALL leave all state unchanged.
REQ-026 Arithmetic SHALL use a 33-bit subtract for the division step, so that no carry is lost when the divisor has bit 31 set under DIVU.

Reset
REQ-027 rst=1 SHALL set state=IDLE, hi=0, lo=0, done=0, busy=0 and counter=0 at the next edge.
REQ-028 rst SHALL override flush and start, and SHALL abort a divide mid-operation without writing hi/lo.

Verification
REQ-029 MULT opA=0xFFFFFFFE (-2), opB=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1, busy stays 0.
REQ-030 DIVU opA=100, opB=7 -> busy high for 33 cycles; cycle 34 lo=14, hi=2, done=1.
REQ-031 DIV opA=-7 (0xFFFFFFF9), opB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-032 DIV opA=5, opB=0 -> hi/lo unchanged, done=1 next cycle, busy never asserts.
REQ-033 DIVU started, flush at cycle 10 -> busy=0 at cycle 11, hi/lo unchanged, no done pulse; a start issued at cycle 5 is ignored.
REQ-034 MTHI opA=0x12345678, then rst asserted during a following DIV -> hi=0x12345678 before the rst edge, then hi=lo=0 and state=IDLE after it.
